// File: rtl/spi_mem_controller.sv
// CPU byte bus to SPI mode-0 memory bridge; stalls the CPU with bus_wait until each frame completes.
// Writes are only issued when SPI_MEM_WRITE_EN is defined; otherwise bus_write is ignored.
module spi_mem_controller #(
  parameter int CLK_DIV    = 1,
  parameter int ADDR_BYTES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic [7:0]  bus_data_out,
  output logic        bus_wait,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_ce
);

  localparam int N   = 8 * (2 + ADDR_BYTES);
  localparam int BCW = $clog2(N + 1);
  localparam int AW  = 8 * ADDR_BYTES;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(N - 1);
  localparam logic [3:0]     DIV_LAST = 4'(CLK_DIV - 1);

`ifdef SPI_MEM_WRITE_EN
  localparam logic WR_EN = 1'b1;
`else
  localparam logic WR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SELECT, SHIFT, DESELECT, DONE} state_t;

  state_t         state;
  logic [N-1:0]   frame_sr;
  logic [BCW-1:0] bit_cnt;
  logic [3:0]     div_cnt;
  logic [7:0]     rx_sr;
  logic           is_read;
  logic           req;
  logic [N-1:0]   frame_new;

  assign req = bus_read | (WR_EN & bus_write);

  // Read wins when both requests are high; read frames carry a zero data byte.
  assign frame_new = {bus_read ? 8'h03 : 8'h02,
                      AW'(bus_address_in),
                      bus_read ? 8'h00 : bus_data_in};

  assign bus_wait = (state == IDLE) ? req : (state != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      frame_sr     <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      rx_sr        <= '0;
      is_read      <= 1'b0;
      spi_ce       <= 1'b1;
      spi_clk      <= 1'b0;
      spi_mosi     <= 1'b0;
      bus_data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            frame_sr <= {frame_new[N-2:0], 1'b0};
            spi_mosi <= frame_new[N-1];
            is_read  <= bus_read;
            spi_ce   <= 1'b0;
            state    <= SELECT;
          end
        end
        SELECT: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!spi_clk) begin
              spi_clk <= 1'b1;
              rx_sr   <= {rx_sr[6:0], spi_miso};
            end else if (bit_cnt == BIT_LAST) begin
              spi_clk  <= 1'b0;
              spi_ce   <= 1'b1;
              spi_mosi <= 1'b0;
              if (is_read) bus_data_out <= rx_sr;
              state    <= DESELECT;
            end else begin
              // Falling edge: present the next frame bit.
              spi_clk  <= 1'b0;
              spi_mosi <= frame_sr[N-1];
              frame_sr <= {frame_sr[N-2:0], 1'b0};
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DESELECT: state <= DONE;
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
